instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
// - RV32 instruction fetch stage: APB master to instruction memory, one transfer in flight.
// - Hands {pc, inst} to decode over a valid/ready handshake.
// - Redirects the PC on jumps and on resolved taken branches.
// - Sits between the imem APB slave and the decode stage.
// PARAMETERS
// - RESET_PC  32'h0000_0000  PC after reset (first fetch address)
// - NOP_INST  32'h0000_0013  instruction delivered on an APB error (addi x0,x0,0)
// PORTS
// - clk                        in   1       clock; all logic on posedge
// - rst_n                      in   1       reset; asynchronous assert, active-low
// - jmp_i                      in   1       1-cycle pulse: jump; new PC = jmp_target_i
// - branch_i                   in   1       1-cycle pulse: decode accepted a branch; stop fetching until it resolves
// - ready_i                    in   1       decode can accept inst_o this cycle
// - branch_cmp_result_valid_i  in   1       branch_cmp_result_i is valid this cycle
// - imem_apb                   apb_if  master side: psel, penable, pwrite(=0), paddr[31:0], pwdata(=0) out; prdata[31:0], pready, pslverr in
// - branch_cmp_result_i        in   1       1 = branch taken
// - jmp_target_i               in   32      target for a jump or a taken branch
// - valid_o                    out  1       pc_o/inst_o hold a fetched instruction
// - branch_taken_o             out  1       1-cycle pulse: taken branch redirected the PC
// - pc_o                       out  32      address of inst_o
// - inst_o                     out  32      fetched instruction word
// BEHAVIOUR
// - Reset values:
//   - fetch_pc=RESET_PC; valid_o=0; branch_taken_o=0; pc_o=0; inst_o=0.
//   - psel=0, penable=0, paddr=0, pwrite=0.
//   - No redirect pending.
// - FSM states: IDLE, SETUP, ACCESS, HOLD, BR_WAIT.
// - IDLE:
//   - Leaving reset with no hold pending, go to SETUP the next cycle.
// - SETUP:
//   - Drive psel=1, penable=0, paddr=fetch_pc. Go to ACCESS.
// - ACCESS:
//   - Drive psel=1, penable=1. Wait for pready.
//   - On pready: inst_o=prdata (NOP_INST if pslverr), pc_o=fetch_pc, valid_o=1; go to HOLD.
//   - A pending redirect discards the data: valid_o stays 0; go to SETUP at the redirect target.
// - HOLD:
//   - pc_o/inst_o/valid_o stable until valid_o&&ready_i at a posedge (handshake).
//   - On handshake: fetch_pc=pc_o+4, valid_o=0, go to SETUP. Minimum 2 cycles from handshake to next valid_o.
// - Addressing:
//   - paddr is always fetch_pc.
//   - PC adds wrap modulo 2^32 (32'hFFFF_FFFC+4 = 0).
//   - jmp_target_i is used unaligned as given; no alignment check.
// - jmp_i (any state): fetch_pc=jmp_target_i, valid_o=0.
//   - In SETUP/ACCESS: the APB transfer is completed, never aborted. Latch the redirect and discard the data.
//   - Otherwise: next state SETUP. Clears BR_WAIT.
// - branch_i (not with jmp_i):
//   - A handshake in the same cycle still advances fetch_pc to pc_o+4.
//   - Then BR_WAIT: no new APB transfer, valid_o=0.
//   - An in-flight transfer finishes and its data is discarded.
// - BR_WAIT on branch_cmp_result_valid_i:
//   - result=1: fetch_pc=jmp_target_i; branch_taken_o=1 for exactly that next cycle; go to SETUP.
//   - result=0: keep fetch_pc (fall-through); go to SETUP.
//   - branch_cmp_result_valid_i outside BR_WAIT is ignored.
// - Simultaneous events:
//   - jmp_i beats branch_i and branch resolution.
//   - Redirect beats a same-cycle pready/handshake: the instruction is dropped, even if ready_i=1.
// - Reset mid-transfer: immediate return to reset values; psel drops asynchronously.
// TESTING
// - Reset, RESET_PC=0, slave mem[i]=i, pready=1, ready_i=1 -> inst_o stream 0,1,2..; pc_o 0,4,8; first valid_o 3 cycles after reset release.
// - ready_i toggling every 2 cycles -> pc_o/inst_o hold while ready_i=0; no instruction skipped or duplicated.
// - branch_i pulse, 2 cycles later cmp_result_valid=1/result=0 -> no APB activity in BR_WAIT; next pc_o = branch pc+4; branch_taken_o stays 0.
// - Same with result=1, jmp_target_i=32'h40 -> branch_taken_o 1-cycle pulse; next pc_o=32'h40.
// - jmp_i during ACCESS with pready delayed 3 cycles, target 32'h100 -> stale data never valid; next pc_o=32'h100.
// - pslverr=1 on the fetch at 32'h8 -> inst_o=32'h0000_0013, pc_o=32'h8; fetching continues at 32'hC.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: RV32 fetch stage, APB master to imem with one transfer in flight,
// delivering {pc, inst} to decode over valid/ready with jump and branch redirects.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        jmp_i,
   input  logic        branch_i,
   input  logic        ready_i,
   input  logic        branch_cmp_result_valid_i,
   input  logic        branch_cmp_result_i,
   input  logic [31:0] jmp_target_i,
   output logic        imem_psel_o,
   output logic        imem_penable_o,
   output logic        imem_pwrite_o,
   output logic [31:0] imem_paddr_o,
   output logic [31:0] imem_pwdata_o,
   input  logic [31:0] imem_prdata_i,
   input  logic        imem_pready_i,
   input  logic        imem_pslverr_i,
   output logic        valid_o,
   output logic        branch_taken_o,
   output logic [31:0] pc_o,
   output logic [31:0] inst_o
);
   typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, BR_WAIT} state_t;

   state_t      state_q, state_d;
   logic [31:0] fetch_pc_q, fetch_pc_d, redir_pc_q, redir_pc_d;
   logic [31:0] pc_q, pc_d, inst_q, inst_d;
   logic        valid_q, valid_d, taken_q, taken_d;
   logic        redir_q, redir_d, br_pend_q, br_pend_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         redir_pc_q <= '0;
         pc_q       <= '0;
         inst_q     <= '0;
         valid_q    <= 1'b0;
         taken_q    <= 1'b0;
         redir_q    <= 1'b0;
         br_pend_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         redir_pc_q <= redir_pc_d;
         pc_q       <= pc_d;
         inst_q     <= inst_d;
         valid_q    <= valid_d;
         taken_q    <= taken_d;
         redir_q    <= redir_d;
         br_pend_q  <= br_pend_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      redir_pc_d = redir_pc_q;
      pc_d       = pc_q;
      inst_d     = inst_q;
      valid_d    = valid_q;
      taken_d    = 1'b0;
      redir_d    = redir_q;
      br_pend_d  = br_pend_q;
      case (state_q)
         IDLE: begin
            fetch_pc_d = jmp_i ? jmp_target_i : fetch_pc_q;
            state_d    = (branch_i && !jmp_i) ? BR_WAIT : SETUP;
         end
         SETUP, ACCESS: begin
            state_d = (state_q == SETUP) ? ACCESS : state_q;
            if (state_q == ACCESS && imem_pready_i) begin
               redir_d   = 1'b0;
               br_pend_d = 1'b0;
               if (jmp_i) begin
                  fetch_pc_d = jmp_target_i;
                  state_d    = SETUP;
               end else if (redir_q) begin
                  fetch_pc_d = redir_pc_q;
                  state_d    = (br_pend_q || branch_i) ? BR_WAIT : SETUP;
               end else if (br_pend_q || branch_i) begin
                  state_d = BR_WAIT;
               end else begin
                  pc_d    = fetch_pc_q;
                  inst_d  = imem_pslverr_i ? NOP_INST : imem_prdata_i;
                  valid_d = 1'b1;
                  state_d = HOLD;
               end
            // Redirect is parked so paddr stays stable until the transfer ends
            end else if (jmp_i) begin
               redir_d    = 1'b1;
               redir_pc_d = jmp_target_i;
               br_pend_d  = 1'b0;
            end else if (branch_i) begin
               br_pend_d = 1'b1;
            end
         end
         HOLD: begin
            if (jmp_i) begin
               fetch_pc_d = jmp_target_i;
               valid_d    = 1'b0;
               state_d    = SETUP;
            end else if (ready_i) begin
               fetch_pc_d = pc_q + 32'd4;
               valid_d    = 1'b0;
               state_d    = branch_i ? BR_WAIT : SETUP;
            end else if (branch_i) begin
               valid_d = 1'b0;
               state_d = BR_WAIT;
            end
         end
         BR_WAIT: begin
            if (jmp_i) begin
               fetch_pc_d = jmp_target_i;
               state_d    = SETUP;
            end else if (branch_cmp_result_valid_i) begin
               fetch_pc_d = branch_cmp_result_i ? jmp_target_i : fetch_pc_q;
               taken_d    = branch_cmp_result_i;
               state_d    = SETUP;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      imem_psel_o    = (state_q == SETUP) || (state_q == ACCESS);
      imem_penable_o = (state_q == ACCESS);
      imem_pwrite_o  = 1'b0;
      imem_paddr_o   = fetch_pc_q;
      imem_pwdata_o  = '0;
      valid_o        = valid_q;
      branch_taken_o = taken_q;
      pc_o           = pc_q;
      inst_o         = inst_q;
   end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed bench with an APB word-memory slave (mem[i] = i)
// and a handshake monitor collecting every instruction decode accepts.
module tb_instr_fetch_unit;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        jmp_i, branch_i, ready_i, cmp_valid, cmp_res;
   logic [31:0] jmp_target_i;
   logic        psel, penable, pwrite, pready, pslverr;
   logic [31:0] paddr, pwdata, prdata;
   logic        valid_o, branch_taken_o;
   logic [31:0] pc_o, inst_o;

   int          n_tests = 0, n_fail = 0;
   int          pwait = 0, acnt = 0, cyc = 0;
   logic        err_en = 1'b0;
   logic [31:0] err_addr = '0;
   logic [31:0] hs_pc[$], hs_inst[$], apb_addr[$];
   logic        hold_pend = 1'b0;
   logic [31:0] hold_pc, hold_inst;
   int          hold_viol = 0, bt_cnt = 0;

   always #5 clk = ~clk;

   instr_fetch_unit dut (
      .clk(clk), .rst_n(rst_n), .jmp_i(jmp_i), .branch_i(branch_i), .ready_i(ready_i),
      .branch_cmp_result_valid_i(cmp_valid), .branch_cmp_result_i(cmp_res),
      .jmp_target_i(jmp_target_i),
      .imem_psel_o(psel), .imem_penable_o(penable), .imem_pwrite_o(pwrite),
      .imem_paddr_o(paddr), .imem_pwdata_o(pwdata), .imem_prdata_i(prdata),
      .imem_pready_i(pready), .imem_pslverr_i(pslverr),
      .valid_o(valid_o), .branch_taken_o(branch_taken_o), .pc_o(pc_o), .inst_o(inst_o)
   );

   assign pready  = psel && penable && (acnt >= pwait);
   assign prdata  = {2'b00, paddr[31:2]};
   assign pslverr = pready && err_en && (paddr == err_addr);

   always @(posedge clk) begin
      acnt <= (psel && penable && !pready) ? acnt + 1 : 0;
      if (rst_n && valid_o && ready_i && !jmp_i) begin
         hs_pc.push_back(pc_o);
         hs_inst.push_back(inst_o);
      end
      if (rst_n && pready) apb_addr.push_back(paddr);
      hold_pend <= rst_n && valid_o && !ready_i && !jmp_i && !branch_i;
      hold_pc   <= pc_o;
      hold_inst <= inst_o;
   end

   always @(negedge clk) begin
      if (hold_pend && !(valid_o && pc_o == hold_pc && inst_o == hold_inst)) hold_viol++;
      if (branch_taken_o) bt_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cyc++;
   endtask

   task automatic do_reset(input logic rdy);
      rst_n = 1'b0;
      {jmp_i, branch_i, cmp_valid, cmp_res} = '0;
      jmp_target_i = '0;
      ready_i = rdy;
      pwait = 0;
      err_en = 1'b0;
      tick();
      tick();
      hs_pc.delete();
      hs_inst.delete();
      apb_addr.delete();
      hold_viol = 0;
      bt_cnt = 0;
   endtask

   task automatic wait_hs(input int n);
      int k = 0;
      while (hs_pc.size() < n && k < 300) begin
         tick();
         k++;
      end
      check("hs_count", 32'(hs_pc.size()), 32'(n));
   endtask

   task automatic wait_pc(input logic [31:0] pc);
      int k = 0;
      while (!(valid_o && pc_o == pc) && k < 100) begin
         tick();
         k++;
      end
      check("reach_pc", {31'b0, valid_o && pc_o == pc}, 32'd1);
   endtask

   task automatic branch_test(input logic res, input logic [31:0] tgt, input logic [31:0] exp_pc);
      int ps = 0;
      do_reset(1'b1);
      rst_n = 1'b1;
      wait_pc(32'h4);
      branch_i = 1'b1;
      tick();
      branch_i = 1'b0;
      repeat (2) begin
         ps += int'(psel);
         tick();
      end
      cmp_valid = 1'b1;
      cmp_res = res;
      jmp_target_i = tgt;
      ps += int'(psel);
      tick();
      cmp_valid = 1'b0;
      cmp_res = 1'b0;
      check("br_no_apb", 32'(ps), 32'd0);
      wait_hs(3);
      check("br_pc", hs_pc[2], exp_pc);
      check("br_inst", hs_inst[2], exp_pc >> 2);
      repeat (3) tick();
      check("br_taken_cnt", 32'(bt_cnt), {31'b0, res});
   endtask

   initial begin
      int k, stale;
      // reset values and first-fetch latency
      do_reset(1'b1);
      check("rst_valid", {31'b0, valid_o}, 32'd0);
      check("rst_psel", {31'b0, psel}, 32'd0);
      check("rst_penable", {31'b0, penable}, 32'd0);
      check("rst_paddr", paddr, 32'd0);
      check("rst_pc", pc_o, 32'd0);
      check("rst_inst", inst_o, 32'd0);
      check("rst_taken", {31'b0, branch_taken_o}, 32'd0);
      check("rst_pwrite", {31'b0, pwrite}, 32'd0);
      rst_n = 1'b1;
      k = 0;
      while (!valid_o && k < 20) begin
         tick();
         k++;
      end
      check("first_valid_lat", 32'(k), 32'd3);
      wait_hs(4);
      for (int i = 0; i < 4; i++) begin
         check("stream_pc", hs_pc[i], 32'(4 * i));
         check("stream_inst", hs_inst[i], 32'(i));
      end

      // ready_i toggling every two cycles
      do_reset(1'b0);
      rst_n = 1'b1;
      k = 0;
      while (hs_pc.size() < 6 && k < 300) begin
         ready_i = ((cyc >> 1) & 1) != 0;
         tick();
         k++;
      end
      check("tog_count", 32'(hs_pc.size()), 32'd6);
      for (int i = 0; i < 6; i++) begin
         check("tog_pc", hs_pc[i], 32'(4 * i));
         check("tog_inst", hs_inst[i], 32'(i));
      end
      check("hold_stable", 32'(hold_viol), 32'd0);

      branch_test(1'b0, 32'h40, 32'h8);
      branch_test(1'b1, 32'h40, 32'h40);

      // jump during a stretched ACCESS
      do_reset(1'b1);
      pwait = 3;
      rst_n = 1'b1;
      k = 0;
      while (!(psel && penable) && k < 20) begin
         tick();
         k++;
      end
      jmp_i = 1'b1;
      jmp_target_i = 32'h100;
      tick();
      jmp_i = 1'b0;
      stale = 0;
      k = 0;
      while (hs_pc.size() < 1 && k < 100) begin
         stale += int'(valid_o && pc_o == 32'h0);
         tick();
         k++;
      end
      check("jmp_stale", 32'(stale), 32'd0);
      check("jmp_pc", hs_pc[0], 32'h100);
      check("jmp_inst", hs_inst[0], 32'h40);
      check("jmp_apb0", apb_addr[0], 32'h0);
      check("jmp_apb1", apb_addr[1], 32'h100);

      // pslverr on the fetch at 0x8
      do_reset(1'b1);
      err_en = 1'b1;
      err_addr = 32'h8;
      rst_n = 1'b1;
      wait_hs(4);
      check("err_pc2", hs_pc[2], 32'h8);
      check("err_inst2", hs_inst[2], 32'h0000_0013);
      check("err_pc3", hs_pc[3], 32'hC);
      check("err_inst3", hs_inst[3], 32'h3);

      // PC wrap after a jump from IDLE
      do_reset(1'b1);
      rst_n = 1'b1;
      jmp_i = 1'b1;
      jmp_target_i = 32'hFFFF_FFFC;
      tick();
      jmp_i = 1'b0;
      wait_hs(2);
      check("wrap_pc0", hs_pc[0], 32'hFFFF_FFFC);
      check("wrap_inst0", hs_inst[0], 32'h3FFF_FFFF);
      check("wrap_pc1", hs_pc[1], 32'h0);

      // jump beats a same-cycle handshake
      do_reset(1'b1);
      rst_n = 1'b1;
      wait_pc(32'h4);
      jmp_i = 1'b1;
      jmp_target_i = 32'h200;
      tick();
      jmp_i = 1'b0;
      wait_hs(3);
      check("jhs_pc1", hs_pc[1], 32'h200);
      check("jhs_inst1", hs_inst[1], 32'h80);
      check("jhs_pc2", hs_pc[2], 32'h204);

      // asynchronous reset in the middle of a transfer
      do_reset(1'b1);
      pwait = 3;
      rst_n = 1'b1;
      k = 0;
      while (!(psel && penable) && k < 20) begin
         tick();
         k++;
      end
      check("mid_psel_pre", {31'b0, psel}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_psel", {31'b0, psel}, 32'd0);
      check("mid_penable", {31'b0, penable}, 32'd0);
      check("mid_valid", {31'b0, valid_o}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
